// File: rtl/csa32_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-select adder, with optional burst lock.
// Define CSA32_ARB_SAT_EN to saturate res_sum to 32'hFFFF_FFFF on unsigned overflow.

module csa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] carry;

  assign carry[0] = 1'b0;

  // Each 4-bit block precomputes both carry-in cases; the ripple carry only drives muxes.
  for (genvar gi = 0; gi < 8; gi++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]};
    assign s1 = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]} + 5'd1;
    assign sum[4*gi +: 4] = carry[gi] ? s1[3:0] : s0[3:0];
    assign carry[gi+1]    = carry[gi] ? s1[4]   : s0[4];
  end

  assign cout = carry[8];
endmodule

module csa32_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_lock,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_sum,
  output logic               res_ovf,
  output logic [IDW-1:0]     res_id,
  output logic               locked
);
  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [IDW:0] NREQ_W     = (IDW+1)'(NREQ);
  localparam logic [8:0]   LOCK_MAX_W = 9'(LOCK_MAX);
  localparam bit           LOCK_EN    = (LOCK_MAX > 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [7:0]     lock_cnt_q, lock_cnt_d;
  logic           res_valid_q, res_valid_d;
  logic [31:0]    res_sum_q, res_sum_d;
  logic           res_ovf_q, res_ovf_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand_w;
  logic           can_accept;
  logic           xfer;
  logic [31:0]    op_a, op_b, add_sum;
  logic           add_cout;
  logic [8:0]     cnt_inc;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    return (v == IDW'(NREQ-1)) ? '0 : v + 1'b1;
  endfunction

  // Search downwards so the candidate closest to ptr is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand_w  = '0;
    if (state_q == LOCKED) begin
      gnt_any = req_valid[owner_q];
      gnt_idx = owner_q;
    end else begin
      for (int k = NREQ-1; k >= 0; k--) begin
        cand_w = {1'b0, ptr_q} + (IDW+1)'(k);
        if (cand_w >= NREQ_W) cand_w = cand_w - NREQ_W;
        if (req_valid[cand_w[IDW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_w[IDW-1:0];
        end
      end
    end
  end

  assign can_accept = !res_valid_q | res_ready;
  assign xfer       = gnt_any & can_accept & rst_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  assign op_a = req_a[{gnt_idx, 5'b0} +: 32];
  assign op_b = req_b[{gnt_idx, 5'b0} +: 32];

  csa32 u_csa (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign cnt_inc = {1'b0, lock_cnt_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    res_id_d    = res_id_q;

    if (xfer) begin
      res_valid_d = 1'b1;
`ifdef CSA32_ARB_SAT_EN
      res_sum_d   = add_cout ? 32'hFFFF_FFFF : add_sum;
`else
      res_sum_d   = add_sum;
`endif
      res_ovf_d   = add_cout;
      res_id_d    = gnt_idx;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (LOCK_EN && req_lock[gnt_idx]) begin
            state_d    = LOCKED;
            owner_d    = gnt_idx;
            lock_cnt_d = 8'd1;
          end else begin
            ptr_d = inc_wrap(gnt_idx);
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (req_lock[owner_q] && (cnt_inc < LOCK_MAX_W)) begin
            lock_cnt_d = cnt_inc[7:0];
          end else begin
            state_d    = IDLE;
            lock_cnt_d = 8'd0;
            ptr_d      = inc_wrap(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      lock_cnt_q  <= 8'd0;
      res_valid_q <= 1'b0;
      res_sum_q   <= 32'd0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_ovf_q   <= res_ovf_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;
  assign locked    = (state_q == LOCKED);
endmodule

// File: tb/tb_csa32_arbiter.sv
// Self-checking bench for csa32_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_csa32_arbiter;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int LOCK_MAX = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_lock;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_sum;
  logic               res_ovf;
  logic [IDW-1:0]     res_id;
  logic               locked;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_ptr, m_owner, m_cnt, m_id;
  bit          m_locked, m_rv, m_ovf;
  logic [31:0] m_sum;

  always #5 clk = ~clk;

  csa32_arbiter #(.NREQ(NREQ), .IDW(IDW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_lock  (req_lock),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .locked    (locked)
  );

  function automatic int model_grant();
    int j;
    if (!rst_n) return -1;
    if (m_rv && !res_ready) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_mask();
    int g;
    logic [NREQ-1:0] m;
    g = model_grant();
    m = '0;
    if (g >= 0) m[g] = 1'b1;
    return m;
  endfunction

  task automatic model_update(input int g);
    logic [32:0] full;
    if (!rst_n) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_id = 0;
      m_locked = 0; m_rv = 0; m_ovf = 0; m_sum = 32'd0;
    end else if (g >= 0) begin
      full  = {1'b0, req_a[32*g +: 32]} + {1'b0, req_b[32*g +: 32]};
      m_ovf = full[32];
`ifdef CSA32_ARB_SAT_EN
      m_sum = full[32] ? 32'hFFFF_FFFF : full[31:0];
`else
      m_sum = full[31:0];
`endif
      m_id  = g;
      m_rv  = 1;
      if (!m_locked) begin
        if (req_lock[g] && LOCK_MAX > 1) begin
          m_locked = 1; m_owner = g; m_cnt = 1;
        end else begin
          m_ptr = (g + 1) % NREQ;
        end
      end else if (req_lock[g] && (m_cnt + 1 < LOCK_MAX)) begin
        m_cnt = m_cnt + 1;
      end else begin
        m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % NREQ;
      end
    end else if (res_ready) begin
      m_rv = 0;
    end
  endtask

  // Advance one clock: model sampled at the negedge, outputs observed 1 time unit after posedge.
  task automatic tick();
    int g;
    @(negedge clk);
    g = model_grant();
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_lock = '0; res_ready = 1'b1;
    req_a = '0; req_b = '0;
    #2;
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tick(); tick();
    n_cmp++;
    if ({res_valid, res_sum, res_ovf, res_id, locked} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b s=%h o=%b id=%0d l=%b exp all zero", res_valid, res_sum, res_ovf, res_id, locked);
    end
    $display("test_reset: done");
    rst_n = 1'b1; req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_sum;
    int exp_id;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1) * 32'h0101_0101, 32'(i) * 32'h10);
    req_valid = '1; req_lock = '0; res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      exp_id  = c % NREQ;
      exp_sum = 32'(exp_id + 1) * 32'h0101_0101 + 32'(exp_id) * 32'h10;
      n_cmp++;
      if (res_valid !== 1'b1 || res_id !== IDW'(exp_id) || res_sum !== exp_sum) begin
        n_bad++;
        $display("FAIL rr_cycle%0d got v=%b id=%0d s=%h exp v=1 id=%0d s=%h", c, res_valid, res_id, res_sum, exp_id, exp_sum);
      end
      $display("rr: cycle %0d id=%0d sum=%h", c, res_id, res_sum);
    end
    req_valid = '0;
  endtask

  task automatic test_single_add();
    set_op(0, 32'h0000_0005, 32'h0000_0007);
    req_valid = 4'b0001;
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 32'h0000_000C || res_ovf !== 1'b0 || res_id !== 2'd0) begin
      n_bad++;
      $display("FAIL single_add got v=%b s=%h o=%b id=%0d exp v=1 s=0000000c o=0 id=0", res_valid, res_sum, res_ovf, res_id);
    end
    $display("single_add: sum=%h ovf=%b id=%0d", res_sum, res_ovf, res_id);
    req_valid = '0;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_sum;
`ifdef CSA32_ARB_SAT_EN
    exp_sum = 32'hFFFF_FFFF;
`else
    exp_sum = 32'h0000_0001;
`endif
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0002);
    req_valid = 4'b0010;
    tick();
    n_cmp++;
    if (res_sum !== exp_sum || res_ovf !== 1'b1 || res_id !== 2'd1) begin
      n_bad++;
      $display("FAIL overflow got s=%h o=%b id=%0d exp s=%h o=1 id=1", res_sum, res_ovf, res_id, exp_sum);
    end
    $display("overflow: sum=%h ovf=%b id=%0d", res_sum, res_ovf, res_id);
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held_sum;
`ifdef CSA32_ARB_SAT_EN
    held_sum = 32'hFFFF_FFFF;
`else
    held_sum = 32'h0000_0001;
`endif
    set_op(2, 32'h1234_0000, 32'h0000_5678);
    res_ready = 1'b0;
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++;
      if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready%0d got=%b exp=0000", c, req_ready); end
      tick();
      n_cmp++;
      if (res_valid !== 1'b1 || res_sum !== held_sum || res_id !== 2'd1) begin
        n_bad++;
        $display("FAIL bp_hold%0d got v=%b s=%h id=%0d exp v=1 s=%h id=1", c, res_valid, res_sum, res_id, held_sum);
      end
      $display("backpressure: cycle %0d held id=%0d", c, res_id);
    end
    res_ready = 1'b1;
    #2;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
    tick();
    n_cmp++;
    if (res_id !== 2'd2 || res_sum !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL bp_release got id=%0d s=%h exp id=2 s=12345678", res_id, res_sum);
    end
    $display("backpressure: released id=%0d sum=%h", res_id, res_sum);
    req_valid = '0;
  endtask

  task automatic test_lock();
    int exp_id;
    bit exp_lk;
    set_op(3, 32'h0000_0300, 32'h0000_0003);
    set_op(0, 32'h0000_0100, 32'h0000_0001);
    req_valid = 4'b1001; req_lock = 4'b1000; res_ready = 1'b1;
    for (int t = 0; t < 9; t++) begin
      tick();
      exp_id = (t < LOCK_MAX) ? 3 : 0;
      exp_lk = (t < LOCK_MAX - 1);
      n_cmp++;
      if (res_id !== IDW'(exp_id) || locked !== exp_lk) begin
        n_bad++;
        $display("FAIL lock_t%0d got id=%0d locked=%b exp id=%0d locked=%b", t, res_id, locked, exp_id, exp_lk);
      end
      $display("lock: transfer %0d id=%0d locked=%b", t, res_id, locked);
    end
    req_valid = '0; req_lock = '0;
  endtask

  task automatic test_reset_mid_lock();
    set_op(3, 32'h0000_0010, 32'h0000_0020);
    set_op(0, 32'h0000_0001, 32'h0000_0001);
    req_valid = 4'b1000; req_lock = 4'b1000; res_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (locked !== 1'b1 || res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midlock_setup got locked=%b v=%b exp 1 1", locked, res_valid);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL midlock_rst_ready got=%b exp=0000", req_ready); end
    tick();
    n_cmp++;
    if ({res_valid, res_sum, res_ovf, res_id, locked} !== 37'd0) begin
      n_bad++;
      $display("FAIL midlock_rst got v=%b s=%h o=%b id=%0d l=%b exp all zero", res_valid, res_sum, res_ovf, res_id, locked);
    end
    rst_n = 1'b1; req_valid = '1; req_lock = '0;
    #2;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midlock_regrant got=%b exp=0001", req_ready); end
    tick();
    n_cmp++;
    if (res_id !== 2'd0 || res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midlock_after got id=%0d v=%b exp id=0 v=1", res_id, res_valid);
    end
    $display("reset_mid_lock: regrant id=%0d", res_id);
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_mask;
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      req_valid = NREQ'($urandom);
      req_lock  = NREQ'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) set_op(i, 32'hFFFF_FFFF - 32'($urandom_range(0, 15)), $urandom);
        else set_op(i, $urandom, $urandom);
      end
      #2;
      exp_mask = model_mask();
      n_cmp++;
      if (req_ready !== exp_mask) begin
        n_bad++;
        $display("FAIL rand_ready%0d got=%b exp=%b", c, req_ready, exp_mask);
      end
      tick();
      n_cmp++;
      if (res_valid !== m_rv || res_sum !== m_sum || res_ovf !== m_ovf ||
          res_id !== IDW'(m_id) || locked !== m_locked) begin
        n_bad++;
        $display("FAIL rand_out%0d got v=%b s=%h o=%b id=%0d l=%b exp v=%b s=%h o=%b id=%0d l=%b",
                 c, res_valid, res_sum, res_ovf, res_id, locked, m_rv, m_sum, m_ovf, m_id, m_locked);
      end
      $display("random: cycle %0d rst_n=%b ready=%b v=%b id=%0d sum=%h locked=%b",
               c, rst_n, exp_mask, res_valid, res_id, res_sum, locked);
    end
    rst_n = 1'b1; req_valid = '0; req_lock = '0; res_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_add();
    test_overflow();
    test_backpressure();
    test_lock();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
